// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with mid-bit majority vote, parity/frame/overrun/break status and ready/valid output.
module uart_rx_param #(
    parameter int N          = 8,
    parameter int M          = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int OVERSAMPLE = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         rx,
    output logic [N-1:0] data_out,
    output logic         valid,
    input  logic         ready,
    output logic         parity_err,
    output logic         frame_err,
    output logic         overrun,
    output logic         break_det,
    output logic         busy
);
    localparam int H  = OVERSAMPLE / 2;
    localparam int SW = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  sc_q, sc_d;
    logic [3:0]     bn_q, bn_d;
    logic [N-1:0]   sh_q, sh_d, dout_q, dout_d;
    logic           s0_q, s0_d, s1_q, s1_d, par_q, par_d, ferr_q, ferr_d;
    logic           done_q, done_d, brk_q, brk_d;
    logic           valid_q, valid_d, perr_q, perr_d, fout_q, fout_d, ovr_q, ovr_d;
    logic           meta_q, rxs_q;
    logic           maj, mid, last_tick, load;

    assign maj       = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
    assign mid       = tick && sc_q == SW'(H + 1);
    assign last_tick = tick && sc_q == SW'(OVERSAMPLE - 1);
    assign load      = done_q & (~valid_q | ready);

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        bn_d    = bn_q;
        sh_d    = sh_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        par_d   = par_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        brk_d   = 1'b0;
        if (tick && state_q != IDLE && state_q != WAIT_IDLE) begin
            sc_d = last_tick ? '0 : sc_q + 1'b1;
            s0_d = sc_q == SW'(H - 1) ? rxs_q : s0_q;
            s1_d = sc_q == SW'(H) ? rxs_q : s1_q;
        end
        case (state_q)
            IDLE: if (!rxs_q) begin
                state_d = START;
                sc_d    = '0;
                ferr_d  = 1'b0;
                par_d   = 1'b0;
            end
            START: if (mid && maj) state_d = IDLE;
                   else if (last_tick) begin
                       state_d = DATA;
                       bn_d    = '0;
                   end
            DATA: begin
                if (mid) sh_d = {maj, sh_q[N-1:1]};
                if (last_tick) begin
                    bn_d = bn_q + 4'd1;
                    if (bn_q == 4'(N - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        bn_d    = '0;
                    end
                end
            end
            PARITY: begin
                if (mid) par_d = maj;
                if (last_tick) begin
                    state_d = STOP;
                    bn_d    = '0;
                end
            end
            STOP: begin
                // The last stop bit completes at its mid-sample so a following start edge is not missed
                if (mid) begin
                    if (bn_q == '0 && !maj && sh_q == '0 && !par_q) begin
                        brk_d   = 1'b1;
                        state_d = WAIT_IDLE;
                        sc_d    = '0;
                    end else if (bn_q == 4'(M - 1)) begin
                        done_d  = 1'b1;
                        ferr_d  = ferr_q | ~maj;
                        state_d = (ferr_q | ~maj) ? WAIT_IDLE : IDLE;
                        sc_d    = '0;
                    end else ferr_d = ferr_q | ~maj;
                end else if (last_tick) bn_d = bn_q + 4'd1;
            end
            WAIT_IDLE: if (!rxs_q) sc_d = '0;
                       else if (tick) begin
                           state_d = sc_q != '0 ? IDLE : WAIT_IDLE;
                           sc_d    = sc_q != '0 ? '0 : SW'(1);
                       end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = load | (valid_q & ~ready);
        dout_d  = load ? sh_q : dout_q;
        perr_d  = load ? ((PARITY_EN != 0) && (((^sh_q) ^ par_q) != 1'(PARITY_ODD))) : perr_q;
        fout_d  = load ? ferr_q : fout_q;
        ovr_d   = (done_q & valid_q & ~ready) | (ovr_q & ~(valid_q & ready));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= IDLE;
            sc_q    <= '0;
            bn_q    <= '0;
            sh_q    <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
            brk_q   <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
            perr_q  <= 1'b0;
            fout_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            meta_q  <= rx;
            rxs_q   <= meta_q;
            state_q <= state_d;
            sc_q    <= sc_d;
            bn_q    <= bn_d;
            sh_q    <= sh_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
            brk_q   <= brk_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
            perr_q  <= perr_d;
            fout_q  <= fout_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out   = dout_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = fout_q;
    assign overrun    = ovr_q;
    assign break_det  = brk_q;
    assign busy       = state_q != IDLE;
endmodule
